// File: rtl/jtag_scan_master_if.sv
// Controller-side bus of jtag_scan_master.
//   master modport: the sequencer (drives start/tapReset/isInstruction/length/dataIn,
//                   receives dataOut/busy/done)
//   slave modport : the scan master itself
interface jtag_scan_master_if #(
  parameter int unsigned MAX_LENGTH = 32
);
  localparam int unsigned LW = $clog2(MAX_LENGTH + 1);

  logic                  start;
  logic                  tapReset;
  logic                  isInstruction;
  logic [LW-1:0]         length;
  logic [MAX_LENGTH-1:0] dataIn;
  logic [MAX_LENGTH-1:0] dataOut;
  logic                  busy;
  logic                  done;

  modport master (
    output start, tapReset, isInstruction, length, dataIn,
    input  dataOut, busy, done
  );

  modport slave (
    input  start, tapReset, isInstruction, length, dataIn,
    output dataOut, busy, done
  );
endinterface

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan master. Runs a complete IR or DR scan (or a TAP reset sequence)
// starting and ending in Run-Test/Idle of the downstream TAP.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   bus (slave)   start/tapReset/isInstruction/length/dataIn in, dataOut/busy/done out
//   jtag_tck/tms/tdi  JTAG pins driven to the TAP
//   jtag_tdo      JTAG data returned from the TAP
// MSB of the active length goes out first; the first captured TDO bit lands in the MSB.
module jtag_scan_master #(
  parameter int unsigned MAX_LENGTH = 32,
  parameter int unsigned CLOCK_DIV  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  jtag_scan_master_if.slave      bus,
  output logic                   jtag_tck,
  output logic                   jtag_tms,
  output logic                   jtag_tdi,
  input  logic                   jtag_tdo
);

  localparam int unsigned LW = $clog2(MAX_LENGTH + 1);
  localparam int unsigned IW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int unsigned DW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  localparam logic [LW-1:0]         MaxLen  = LW'(MAX_LENGTH);
  localparam logic [DW-1:0]         DivLast = DW'(CLOCK_DIV - 1);
  localparam logic [MAX_LENGTH-1:0] OneVec  = MAX_LENGTH'(1);

  // One state per TAP-facing phase; each non-idle state lasts one or more TCK cycles.
  typedef enum logic [2:0] {
    StIdle,
    StResetSeq,
    StSelect,
    StCapture,
    StShift,
    StExitUpdate,
    StReturn
  } state_e;

  state_e                r_state, w_state_d;
  logic [DW-1:0]         r_div, w_div_d;
  logic                  r_tck, w_tck_d;
  logic                  r_tms, w_tms_d;
  logic                  r_tdi, w_tdi_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic [2:0]            r_step, w_step_d;
  logic [IW-1:0]         r_bit, w_bit_d;
  logic                  r_ir, w_ir_d;
  logic [MAX_LENGTH-1:0] r_din, w_din_d;
  logic [MAX_LENGTH-1:0] r_dout, w_dout_d;

  logic [LW-1:0]         w_len;
  logic [LW-1:0]         w_len_m1;
  logic [MAX_LENGTH-1:0] w_keep;
  logic [IW-1:0]         w_bit_m1;

  assign w_len    = (bus.length > MaxLen) ? MaxLen : bus.length;
  assign w_len_m1 = w_len - LW'(1);
  // Ones in [n-1:0]; wraps to all ones when n == MAX_LENGTH.
  assign w_keep   = (OneVec << w_len) - OneVec;
  assign w_bit_m1 = r_bit - IW'(1);

  always_comb begin
    w_state_d = r_state;
    w_div_d   = r_div;
    w_tck_d   = r_tck;
    w_tms_d   = r_tms;
    w_tdi_d   = r_tdi;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_step_d  = r_step;
    w_bit_d   = r_bit;
    w_ir_d    = r_ir;
    w_din_d   = r_din;
    w_dout_d  = r_dout;

    case (r_state)
      StIdle: begin
        w_div_d = '0;
        w_tck_d = 1'b0;
        w_tms_d = 1'b0;
        w_tdi_d = 1'b0;
        if (bus.tapReset) begin
          w_state_d = StResetSeq;
          w_busy_d  = 1'b1;
          w_tms_d   = 1'b1;
          w_step_d  = '0;
        end else if (bus.start) begin
          if (w_len == '0) begin
            w_done_d = 1'b1;
          end else begin
            w_state_d = StSelect;
            w_busy_d  = 1'b1;
            w_tms_d   = 1'b1;
            w_step_d  = '0;
            w_ir_d    = bus.isInstruction;
            w_din_d   = bus.dataIn;
            w_bit_d   = IW'(w_len_m1);
            w_dout_d  = r_dout & w_keep;
          end
        end
      end

      default: begin
        if (r_div != DivLast) begin
          w_div_d = r_div + DW'(1);
        end else begin
          w_div_d = '0;
          if (!r_tck) begin
            // Rising TCK: TDO is captured on this same clk edge.
            w_tck_d = 1'b1;
            if (r_state == StShift) begin
              w_dout_d[r_bit] = jtag_tdo;
            end
          end else begin
            // Falling TCK ends a TCK cycle; set up TMS/TDI for the next one.
            w_tck_d = 1'b0;
            w_tdi_d = 1'b0;
            case (r_state)
              StResetSeq: begin
                if (r_step == 3'd4) begin
                  w_state_d = StReturn;
                  w_tms_d   = 1'b0;
                end else begin
                  w_step_d = r_step + 3'd1;
                  w_tms_d  = 1'b1;
                end
              end
              StSelect: begin
                // IR path needs a second TMS=1 to reach Select-IR.
                if (r_ir && (r_step == 3'd0)) begin
                  w_step_d = 3'd1;
                  w_tms_d  = 1'b1;
                end else begin
                  w_state_d = StCapture;
                  w_step_d  = '0;
                  w_tms_d   = 1'b0;
                end
              end
              StCapture: begin
                if (r_step == 3'd0) begin
                  w_step_d = 3'd1;
                  w_tms_d  = 1'b0;
                end else begin
                  w_state_d = StShift;
                  w_tms_d   = (r_bit == '0);
                  w_tdi_d   = r_din[r_bit];
                end
              end
              StShift: begin
                if (r_bit == '0) begin
                  w_state_d = StExitUpdate;
                  w_tms_d   = 1'b1;
                end else begin
                  w_bit_d = w_bit_m1;
                  w_tms_d = (w_bit_m1 == '0);
                  w_tdi_d = r_din[w_bit_m1];
                end
              end
              StExitUpdate: begin
                w_state_d = StReturn;
                w_tms_d   = 1'b0;
              end
              StReturn: begin
                w_state_d = StIdle;
                w_tms_d   = 1'b0;
                w_busy_d  = 1'b0;
                w_done_d  = 1'b1;
              end
              default: begin
                w_state_d = StIdle;
                w_tms_d   = 1'b0;
                w_busy_d  = 1'b0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b0;
      r_tdi   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_step  <= '0;
      r_bit   <= '0;
      r_ir    <= 1'b0;
      r_din   <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_d;
      r_div   <= w_div_d;
      r_tck   <= w_tck_d;
      r_tms   <= w_tms_d;
      r_tdi   <= w_tdi_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_step  <= w_step_d;
      r_bit   <= w_bit_d;
      r_ir    <= w_ir_d;
      r_din   <= w_din_d;
      r_dout  <= w_dout_d;
    end
  end

  assign jtag_tck    = r_tck;
  assign jtag_tms    = r_tms;
  assign jtag_tdi    = r_tdi;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dataOut = r_dout;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP on the pins, scoreboard of expected
// scan results, and a monitor that checks each completion against the scoreboard.
module tb_jtag_scan_master;

  localparam int unsigned M  = 32;
  localparam int unsigned CD = 2;
  localparam int unsigned LW = $clog2(M + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jtag_tck, jtag_tms, jtag_tdi;
  logic tap_tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_scan_master_if #(.MAX_LENGTH(M)) ctl ();

  jtag_scan_master #(
    .MAX_LENGTH (M),
    .CLOCK_DIV  (CD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ctl),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (tap_tdo)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural TAP (IEEE 1149.1 state graph) ----------------
  typedef enum int {Tlr, Rti, Sdr, Cdr, Shdr, E1dr, Pdr, E2dr, Udr,
                    Sir, Cir, Shir, E1ir, Pir, E2ir, Uir} tap_e;

  tap_e           tap_state = Tlr;
  logic [M-1:0]   tap_sh    = '0;
  logic [M-1:0]   dr_upd    = '0;
  logic [M-1:0]   ir_upd    = '0;
  int             tap_len   = 1;   // active register length for the current scan
  logic [M-1:0]   tap_cap   = '0;  // value captured into that register

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      Tlr:  return tms ? Tlr  : Rti;
      Rti:  return tms ? Sdr  : Rti;
      Sdr:  return tms ? Sir  : Cdr;
      Cdr:  return tms ? E1dr : Shdr;
      Shdr: return tms ? E1dr : Shdr;
      E1dr: return tms ? Udr  : Pdr;
      Pdr:  return tms ? E2dr : Pdr;
      E2dr: return tms ? Udr  : Shdr;
      Udr:  return tms ? Sdr  : Rti;
      Sir:  return tms ? Tlr  : Cir;
      Cir:  return tms ? E1ir : Shir;
      Shir: return tms ? E1ir : Shir;
      E1ir: return tms ? Uir  : Pir;
      Pir:  return tms ? E2ir : Pir;
      E2ir: return tms ? Uir  : Shir;
      default: return tms ? Sdr : Rti;
    endcase
  endfunction

  function automatic logic [M-1:0] low_mask(input int n);
    logic [M-1:0] m = '0;
    for (int i = 0; i < n && i < M; i++) m[i] = 1'b1;
    return m;
  endfunction

  always @(posedge jtag_tck) begin
    case (tap_state)
      Cdr, Cir:   tap_sh = tap_cap & low_mask(tap_len);
      Shdr, Shir: tap_sh = ((tap_sh << 1) | M'(jtag_tdi)) & low_mask(tap_len);
      Udr:        dr_upd = tap_sh;
      Uir:        ir_upd = tap_sh;
      default: ;
    endcase
    tap_state = tap_next(tap_state, jtag_tms);
  end

  // Register MSB drives TDO, updated on the falling edge.
  always @(negedge jtag_tck) begin
    if ((tap_state == Shdr || tap_state == Shir) && tap_len > 0) tap_tdo = tap_sh[tap_len-1];
    else tap_tdo = 1'b0;
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int           ntck;
    logic [127:0] tms;
    logic [127:0] tdi;
    logic [M-1:0] dout;
    logic [M-1:0] upd;
    bit           chk_upd;
    bit           ir;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t exp_q[$];
  logic [M-1:0] model_dout = '0;

  function automatic exp_t build(input bit rst_seq, input bit ir, input int n,
                                 input logic [M-1:0] din, input logic [M-1:0] cap,
                                 input logic [M-1:0] prev);
    exp_t e;
    int p = 0;
    e.tms = '0; e.tdi = '0; e.upd = '0; e.chk_upd = 1'b0; e.ir = ir; e.t_acc = 0;
    e.dout = prev;
    if (rst_seq) begin
      for (int i = 0; i < 5; i++) begin e.tms[p] = 1'b1; p++; end
      p++;
    end else if (n > 0) begin
      e.tms[p] = 1'b1; p++;
      if (ir) begin e.tms[p] = 1'b1; p++; end
      p += 2;
      for (int k = 0; k < n; k++) begin
        e.tms[p] = (k == n - 1);
        e.tdi[p] = din[n-1-k];
        p++;
      end
      e.tms[p] = 1'b1; p++;
      p++;
      e.dout = cap & low_mask(n);
      e.upd = din & low_mask(n);
      e.chk_upd = 1'b1;
    end
    e.ntck = p;
    e.lat = p * 2 * int'(CD);
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic [127:0] obs_tms = '0, obs_tdi = '0;
  int   obs_n = 0, run = 0, phase_err = 0;
  bit   prev_busy = 0, prev_done = 0;
  logic prev_tck = 0, prev_tms = 0, prev_tdi = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      obs_n = 0; obs_tms = '0; obs_tdi = '0; phase_err = 0; run = 0;
    end else begin
      if (ctl.busy === 1'b1) begin
        if (!prev_busy) begin
          if (jtag_tck !== 1'b0) phase_err++;
          run = 1;
        end else if (jtag_tck == prev_tck) begin
          run++;
          if (jtag_tms != prev_tms || jtag_tdi != prev_tdi) phase_err++;
        end else begin
          if (run != int'(CD)) phase_err++;
          run = 1;
          if (jtag_tck) begin
            // TMS/TDI may only move as a low phase starts
            if (jtag_tms != prev_tms || jtag_tdi != prev_tdi) phase_err++;
            if (obs_n < 128) begin
              obs_tms[obs_n] = jtag_tms;
              obs_tdi[obs_n] = jtag_tdi;
            end
            obs_n++;
          end
        end
      end else if (jtag_tck !== 1'b0) begin
        phase_err++;
      end

      if (ctl.done === 1'b1) begin
        if (prev_done) begin
          n_checks++; n_fail++;
          $display("FAIL done_width: done high for 2+ cycles, expected 1");
        end
        if (prev_busy && run != int'(CD)) phase_err++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: done with no outstanding request at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latency",      cyc - mon_e.t_acc, mon_e.lat);
          chk("tck_count",    obs_n, mon_e.ntck);
          chk("tms_seq",      obs_tms, mon_e.tms);
          chk("tdi_seq",      obs_tdi, mon_e.tdi);
          chk("dataOut",      ctl.dataOut, mon_e.dout);
          chk("busy_at_done", ctl.busy, 1'b0);
          chk("tms_at_done",  jtag_tms, 1'b0);
          chk("tck_timing",   phase_err, 0);
          if (mon_e.ntck > 0) chk("tap_state", int'(tap_state), int'(Rti));
          if (mon_e.chk_upd) chk("tap_update", mon_e.ir ? ir_upd : dr_upd, mon_e.upd);
        end
        obs_n = 0; obs_tms = '0; obs_tdi = '0; phase_err = 0; run = 0;
      end
    end
    prev_busy = (ctl.busy === 1'b1);
    prev_done = (ctl.done === 1'b1);
    prev_tck  = jtag_tck;
    prev_tms  = jtag_tms;
    prev_tdi  = jtag_tdi;
  end

  // ---------------- stimulus ----------------
  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: %0d request(s) still outstanding after %0d cycles", exp_q.size(), t);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input bit do_start, input bit do_rst, input bit ir, input int len,
                       input logic [M-1:0] din, input logic [M-1:0] cap,
                       input int hold, input bit pulse2);
    exp_t e;
    int n;
    n = (len > int'(M)) ? int'(M) : len;
    if (!do_rst) begin
      tap_len = n;
      tap_cap = cap;
    end
    e = build(do_rst, ir, n, din, cap, model_dout);
    if (!do_rst && n > 0) model_dout = e.dout;
    @(negedge clk);
    ctl.start = do_start;
    ctl.tapReset = do_rst;
    ctl.isInstruction = ir;
    ctl.length = LW'(len);
    ctl.dataIn = din;
    @(posedge clk);
    #1;
    e.t_acc = cyc;
    exp_q.push_back(e);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      ctl.start = 1'b0;
      ctl.tapReset = 1'b0;
      if (pulse2) begin
        repeat (4) @(negedge clk);
        ctl.start = 1'b1;
        ctl.tapReset = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        ctl.tapReset = 1'b0;
      end
    end else begin
      ctl.start = 1'b0;
      ctl.tapReset = 1'b0;
    end
    // Inputs must have been latched; scramble them while the scan runs.
    ctl.dataIn = M'($urandom);
    ctl.length = LW'($urandom_range(0, 40));
    ctl.isInstruction = 1'($urandom_range(0, 1));
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl.start = 1'b0;
    ctl.tapReset = 1'b0;
    ctl.isInstruction = 1'b0;
    ctl.length = '0;
    ctl.dataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck",     jtag_tck, 1'b0);
    chk("rst_tms",     jtag_tms, 1'b0);
    chk("rst_tdi",     jtag_tdi, 1'b0);
    chk("rst_busy",    ctl.busy, 1'b0);
    chk("rst_done",    ctl.done, 1'b0);
    chk("rst_dataOut", ctl.dataOut, '0);
    rst = 1'b0;

    // TAP reset sequence, then directed scans
    issue(1'b0, 1'b1, 1'b0, 0, '0, '0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 8, M'(32'hA5), M'(32'h3C), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 5, M'(32'h11), M'($urandom), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1, M'(32'h1), M'(32'h1), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 1, M'(32'h0), M'(32'h1), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 0, M'($urandom), M'($urandom), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 40, M'($urandom), M'($urandom), 0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 32, M'($urandom), M'($urandom), 0, 1'b0);
    // start held, plus a second start/tapReset pulse mid-scan
    issue(1'b1, 1'b0, 1'b0, 8, M'(32'h5A), M'(32'hC3), 10, 1'b1);
    // start and tapReset together: reset sequence only
    issue(1'b1, 1'b1, 1'b0, 8, M'($urandom), M'($urandom), 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) == 0)
        issue(1'b0, 1'b1, 1'b0, 0, '0, '0, 0, 1'b0);
      else
        issue(1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
              M'($urandom), M'($urandom), 0, 1'b0);
    end

    // reset in the middle of a shift
    tap_len = 16;
    tap_cap = M'($urandom) | M'(1);
    @(negedge clk);
    ctl.start = 1'b1;
    ctl.isInstruction = 1'b0;
    ctl.length = LW'(16);
    ctl.dataIn = M'($urandom);
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("busy_mid_scan", ctl.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tck",     jtag_tck, 1'b0);
    chk("midrst_tms",     jtag_tms, 1'b0);
    chk("midrst_busy",    ctl.busy, 1'b0);
    chk("midrst_done",    ctl.done, 1'b0);
    chk("midrst_dataOut", ctl.dataOut, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_dout = '0;
    issue(1'b0, 1'b1, 1'b0, 0, '0, '0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 12, M'($urandom), M'($urandom), 0, 1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
